// File: rtl/issue_stage_latch.sv
// Schedule-to-issue pipeline latch: holds per-lane {valid, IQ pointer} under stall,
// kills flushed ops, and generates IQ entry releases as ops leave the issue stage.
module issue_stage_latch #(
  parameter int ISSUE_WIDTH           = 5,
  parameter int ISSUE_QUEUE_ENTRY_NUM = 16,
  parameter int IQ_INDEX_WIDTH        = $clog2(ISSUE_QUEUE_ENTRY_NUM),
  parameter int COUNT_WIDTH           = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  stall,
  input  logic                                  clear,
  input  logic [ISSUE_WIDTH-1:0]                in_valid,
  input  logic [ISSUE_WIDTH*IQ_INDEX_WIDTH-1:0] in_iq_ptr,
  input  logic [ISSUE_QUEUE_ENTRY_NUM-1:0]      flush_iq_entry,
  output logic [ISSUE_WIDTH-1:0]                out_valid,
  output logic [ISSUE_WIDTH*IQ_INDEX_WIDTH-1:0] out_iq_ptr,
  output logic [ISSUE_WIDTH-1:0]                release_valid,
  output logic [ISSUE_WIDTH*IQ_INDEX_WIDTH-1:0] release_ptr,
  output logic [ISSUE_QUEUE_ENTRY_NUM-1:0]      inflight_bitmap,
  output logic [COUNT_WIDTH-1:0]                issue_count,
  output logic                                  dup_error
);

  logic [ISSUE_WIDTH-1:0]    valid_q, valid_d;
  logic [IQ_INDEX_WIDTH-1:0] ptr_q [ISSUE_WIDTH];
  logic [IQ_INDEX_WIDTH-1:0] ptr_d [ISSUE_WIDTH];
  logic [COUNT_WIDTH-1:0]    release_cnt;
  logic                      dup_d;

  always_comb begin
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      ptr_d[i]   = ptr_q[i];
      valid_d[i] = 1'b0;
      if (clear) begin
        valid_d[i] = 1'b0;
      end else if (stall) begin
        valid_d[i] = valid_q[i] && !flush_iq_entry[ptr_q[i]];
      end else begin
        ptr_d[i]   = in_iq_ptr[i*IQ_INDEX_WIDTH +: IQ_INDEX_WIDTH];
        valid_d[i] = in_valid[i] && !flush_iq_entry[ptr_d[i]];
      end
    end
  end

  // Duplicate check uses the post-update values so the flag rises together
  // with the registered state that holds the duplicate.
  always_comb begin
    dup_d = 1'b0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      for (int unsigned j = i + 1; j < ISSUE_WIDTH; j++) begin
        if (valid_d[i] && valid_d[j] && (ptr_d[i] == ptr_d[j])) dup_d = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid       = '0;
    out_iq_ptr      = '0;
    inflight_bitmap = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      out_valid[i] = valid_q[i] && !flush_iq_entry[ptr_q[i]];
      out_iq_ptr[i*IQ_INDEX_WIDTH +: IQ_INDEX_WIDTH] = ptr_q[i];
      if (valid_q[i]) inflight_bitmap[ptr_q[i]] = 1'b1;
    end
  end

  always_comb begin
    release_valid = out_valid & {ISSUE_WIDTH{!(stall || clear)}};
    release_ptr   = out_iq_ptr;
    release_cnt   = '0;
    for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
      release_cnt = release_cnt + COUNT_WIDTH'(release_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      issue_count <= '0;
      dup_error   <= 1'b0;
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) ptr_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      issue_count <= issue_count + release_cnt;
      dup_error   <= dup_error | dup_d;
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) ptr_q[i] <= ptr_d[i];
    end
  end

endmodule
